regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// Parametrised multi-port integer register file for the pipelined core; replaces the fixed 2R1W file.
// Provides NRD combinational read ports with same-cycle write bypass, two write ports (ALU/LSU writeback),
// a per-register pending-write scoreboard for hazard detection, and a post-reset clearing sweep.
// Sits between decode (reads, issue) and writeback (writes); a0 tap feeds the host/result monitor.
// PARAMETERS
// XLEN      32  data width in bits
// NREG      32  number of registers (power of 2, >=2); AW = $clog2(NREG)
// NRD       2   number of read ports (1..4)
// ZERO_REG  1   1: register 0 is hardwired zero (writes/issues to it ignored)
// RET_IDX   10  index exposed on ret_val (a0)
// PORTS
// CLK       in   1         clock, all state updates on posedge
// RST_X     in   1         reset, asynchronous, active-high
// ready     out  1         1 = init sweep done, file accepts reads/writes
// rs_addr   in   NRD*AW    read addresses, port i at [i*AW +: AW]
// rs_data   out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
// rs_busy   out  NRD       port i source has an outstanding producer
// we0/we1   in   1         write enables (port 0 = ALU, port 1 = LSU)
// wa0/wa1   in   AW        write addresses
// wd0/wd1   in   XLEN      write data
// iss_v     in   1         instruction issued with destination iss_rd
// iss_rd    in   AW        destination of issued instruction
// ret_val   out  XLEN      contents of register RET_IDX
// BEHAVIOUR
// - RST_X high (async, any time incl. mid-sweep): state=INIT, sweep counter=0, ready=0, all pending bits 0,
//   rs_data/rs_busy/ret_val forced 0 while RST_X high.
// - INIT: after RST_X falls, one register zeroed per cycle, index = counter, counter 0..NREG-1;
//   on cycle writing NREG-1 -> READY, ready=1 next cycle. Sweep takes exactly NREG cycles.
//   In INIT: we0/we1/iss_v ignored, rs_data=0, rs_busy=0, ret_val=0.
// - READY: write x[waN]<=wdN at posedge when weN. Both ports same address: port 1 (LSU) wins.
//   ZERO_REG=1: writes to index 0 dropped; reads of 0 always return 0, rs_busy=0.
// - Reads combinational, 0 cycles latency. Bypass: if weN && waN==rs_addr_i (and not hardwired 0)
//   rs_data_i = wdN (port 1 priority), else stored value. ret_val bypasses identically.
// - Scoreboard pending[NREG]: posedge: iss_v sets pending[iss_rd]; weN clears pending[waN].
//   Set and clear same index same cycle: set wins (newer producer). iss_rd==0 with ZERO_REG: no effect.
//   Re-issue to already-pending register: stays 1 (no count; in-order writeback guaranteed by pipeline).
// - rs_busy_i = pending[rs_addr_i] & ~(write hit on rs_addr_i this cycle); combinational.
// - Out-of-range never occurs (NREG power of 2). No X on outputs after first posedge with RST_X low.
// TESTING
// - RST_X pulse, NREG=32: ready=0 for 32 cycles, 1 on cycle 33; all 32 reads return 0; writes during INIT lost.
// - READY, we0 wa0=5 wd0=0xDEADBEEF, rs_addr0=5 same cycle -> rs_data0=0xDEADBEEF (bypass); next cycle stored.
// - we0 wa0=7 wd0=1 and we1 wa1=7 wd1=2 same cycle -> x7=2; rs_data reading 7 that cycle =2.
// - write wa0=0 wd0=0xFFFF_FFFF, ZERO_REG=1 -> read of x0 = 0; iss_v iss_rd=0 -> rs_busy for 0 stays 0.
// - iss_v rd=3 -> rs_busy=1 for rs=3; same cycle iss_v rd=3 and we1 wa1=3 -> pending stays 1; we0 wa0=3 alone -> busy 0.
// - Assert RST_X mid-sweep (counter=17) and mid-traffic -> ready=0, pending cleared, sweep restarts, 32 cycles again.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus between the pipeline (decode/issue/writeback) and the multi-port register file.
// The master modport belongs to the core side and the slave modport belongs to the register file.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int AW   = 5
);
    logic                ready;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                iss_v;
    logic [AW-1:0]       iss_rd;
    logic [XLEN-1:0]     ret_val;

    modport master (
        input  ready, rs_data, rs_busy, ret_val,
        output rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_rd
    );

    modport slave (
        output ready, rs_data, rs_busy, ret_val,
        input  rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_rd
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD bypassed read ports, ALU/LSU write ports,
// a pending-write scoreboard, and a post-reset sweep that zeroes one register per cycle.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int RET_IDX  = 10
) (
    input  logic        CLK,
    input  logic        RST_X,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] RET_AW   = AW'(RET_IDX);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t          state;
    logic [AW-1:0]   sweep_cnt;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic active;
    logic wr0;
    logic wr1;
    logic iss;

    // Index 0 is dropped here so no downstream logic has to special-case it.
    always_comb begin
        active = (state == ST_READY) && !RST_X;
        wr0    = active && bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0);
        wr1    = active && bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);
        iss    = active && bus.iss_v && !(ZERO_REG != 0 && bus.iss_rd == '0);
    end

    function automatic logic write_hit(
        input logic [AW-1:0] a,
        input logic w0, input logic [AW-1:0] a0,
        input logic w1, input logic [AW-1:0] a1
    );
        return (w0 && a0 == a) || (w1 && a1 == a);
    endfunction

    function automatic logic [XLEN-1:0] read_bypass(
        input logic [AW-1:0]   a,
        input logic            act,
        input logic [XLEN-1:0] stored,
        input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
        input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1
    );
        if (!act || (ZERO_REG != 0 && a == '0)) return '0;
        if (w1 && a1 == a) return d1;
        if (w0 && a0 == a) return d0;
        return stored;
    endfunction

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_IDX) state <= ST_READY;
                end
                ST_READY: state <= ST_READY;
                default:  state <= ST_INIT;
            endcase
        end
    end

    // NOTE: the storage array has no reset term; the INIT sweep clears it one entry per
    // cycle, which keeps it mappable to RAM and off the async-reset tree.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            if (state == ST_INIT) begin
                mem[sweep_cnt] <= '0;
            end else begin
                if (wr0) mem[bus.wa0] <= bus.wd0;
                // NOTE: the later non-blocking assignment wins, giving LSU priority on a shared address.
                if (wr1) mem[bus.wa1] <= bus.wd1;
            end
        end
    end

    // A same-cycle issue overrides a writeback clear: the issue is the newer producer.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NREG; i++) begin
            if (iss && bus.iss_rd == AW'(i))
                pending_nxt[i] = 1'b1;
            else if (write_hit(AW'(i), wr0, bus.wa0, wr1, bus.wa1))
                pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) pending <= '0;
        else       pending <= pending_nxt;
    end

    always_comb begin
        bus.rs_data = '0;
        bus.rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rs_data[i*XLEN +: XLEN] = read_bypass(
                bus.rs_addr[i*AW +: AW], active, mem[bus.rs_addr[i*AW +: AW]],
                wr0, bus.wa0, bus.wd0, wr1, bus.wa1, bus.wd1);
            bus.rs_busy[i] = active && pending[bus.rs_addr[i*AW +: AW]] &&
                !write_hit(bus.rs_addr[i*AW +: AW], wr0, bus.wa0, wr1, bus.wa1);
        end
    end

    always_comb begin
        bus.ready   = (state == ST_READY) && !RST_X;
        bus.ret_val = read_bypass(RET_AW, active, mem[RET_AW],
                                  wr0, bus.wa0, bus.wd0, wr1, bus.wa1, bus.wd1);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: the driver pushes expected outputs into a scoreboard and
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_mp;
    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int NRD     = 2;
    localparam int AW      = 5;
    localparam int RET_IDX = 10;

    logic CLK = 1'b0;
    logic RST_X = 1'b1;
    always #5 CLK = ~CLK;

    regfile_mp_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus ();

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .RET_IDX(RET_IDX)
    ) dut (
        .CLK  (CLK),
        .RST_X(RST_X),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic [XLEN-1:0]     ret;
        logic                rdy;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    logic [XLEN-1:0] regs [NREG];
    bit              pend [NREG];
    int              low_cycles = 0;
    bit              in_reset   = 1'b1;
    int              hot [5] = '{0, 3, 5, 7, 10};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !in_reset && low_cycles >= NREG;
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input int a, input bit rdy,
        input bit we0, input int wa0, input logic [XLEN-1:0] wd0,
        input bit we1, input int wa1, input logic [XLEN-1:0] wd1);
        if (!rdy || a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return regs[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit rdy,
        input bit we0, input int wa0, input bit we1, input int wa1);
        return rdy && a != 0 && pend[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    // Drives one cycle, records what the outputs must show during it, then applies
    // the architectural effect of that cycle to the model at the clock edge.
    task automatic step(input string tag,
        input bit we0, input int wa0, input logic [XLEN-1:0] wd0,
        input bit we1, input int wa1, input logic [XLEN-1:0] wd1,
        input bit iss, input int rd, input int ra0, input int ra1);
        exp_t e;
        bit   rdy;
        bus.we0 = we0;  bus.wa0 = AW'(wa0);  bus.wd0 = wd0;
        bus.we1 = we1;  bus.wa1 = AW'(wa1);  bus.wd1 = wd1;
        bus.iss_v = iss; bus.iss_rd = AW'(rd);
        bus.rs_addr = {AW'(ra1), AW'(ra0)};
        rdy = model_ready();
        e.rdy  = rdy;
        e.data = {exp_read(ra1, rdy, we0, wa0, wd0, we1, wa1, wd1),
                  exp_read(ra0, rdy, we0, wa0, wd0, we1, wa1, wd1)};
        e.busy = {exp_busy(ra1, rdy, we0, wa0, we1, wa1),
                  exp_busy(ra0, rdy, we0, wa0, we1, wa1)};
        e.ret  = exp_read(RET_IDX, rdy, we0, wa0, wd0, we1, wa1, wd1);
        sb.push_back(e);
        tag_q.push_back(tag);
        @(posedge CLK);
        if (!in_reset) begin
            if (!rdy) begin
                low_cycles++;
            end else begin
                if (we0 && wa0 != 0) regs[wa0] = wd0;
                if (we1 && wa1 != 0) regs[wa1] = wd1;
                if (we0) pend[wa0] = 1'b0;
                if (we1) pend[wa1] = 1'b0;
                if (iss && rd != 0) pend[rd] = 1'b1;
            end
        end
        #1;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
        return hot[$urandom_range(0, 4)];
    endfunction

    task automatic rand_step(input string tag);
        step(tag, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                  $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                  $urandom_range(0, 2) == 0, rand_addr(), rand_addr(), rand_addr());
    endtask

    task automatic rd_step(input string tag, input int ra0, input int ra1);
        step(tag, 0, 0, '0, 0, 0, '0, 0, 0, ra0, ra1);
    endtask

    // Reset is raised just after an edge, held for one checked cycle with random inputs,
    // and released just after the following edge.
    task automatic reset_pulse();
        RST_X = 1'b1;
        in_reset = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < NREG; i++) begin
            regs[i] = '0;
            pend[i] = 1'b0;
        end
        rand_step("in_reset");
        RST_X = 1'b0;
        in_reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                t = tag_q.pop_front();
                check({t, ".ready"},   64'(bus.ready),   64'(e.rdy));
                check({t, ".rs_data"}, 64'(bus.rs_data), 64'(e.data));
                check({t, ".rs_busy"}, 64'(bus.rs_busy), 64'(e.busy));
                check({t, ".ret_val"}, 64'(bus.ret_val), 64'(e.ret));
            end
        end
    end

    initial begin : driver
        bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0;
        bus.iss_v = 0; bus.iss_rd = '0; bus.rs_addr = '0;
        @(posedge CLK);
        #1;
        reset_pulse();
        for (int i = 0; i < NREG; i++) rand_step("sweep");
        for (int i = 0; i < NREG / 2; i++) rd_step("post_sweep", 2 * i, 2 * i + 1);

        step("bypass5", 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 5, 0);
        rd_step("stored5", 5, 0);
        step("dual7", 1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 7, 5);
        rd_step("stored7", 7, 5);
        step("wr_x0", 1, 0, 32'hFFFF_FFFF, 0, 0, '0, 0, 0, 0, 5);
        step("iss_x0", 0, 0, '0, 0, 0, '0, 1, 0, 0, 7);
        rd_step("read_x0", 0, 0);
        step("iss3", 0, 0, '0, 0, 0, '0, 1, 3, 3, 0);
        rd_step("busy3", 3, 3);
        step("iss3_wb3", 0, 0, '0, 1, 3, 32'h33, 1, 3, 3, 0);
        rd_step("busy3_kept", 3, 0);
        step("wb3_alu", 1, 3, 32'h44, 0, 0, '0, 0, 0, 0, 3);
        rd_step("busy3_clear", 3, 0);
        step("ret_wr", 1, RET_IDX, 32'hA0A0_0001, 0, 0, '0, 0, 0, RET_IDX, 0);
        rd_step("ret_stored", 0, RET_IDX);

        for (int i = 0; i < 300; i++) rand_step("rand_a");

        reset_pulse();
        for (int i = 0; i < 17; i++) rand_step("sweep_cut");
        reset_pulse();
        for (int i = 0; i < NREG; i++) rand_step("sweep2");
        for (int i = 0; i < NREG / 2; i++) rd_step("post_sweep2", 2 * i, 2 * i + 1);

        for (int i = 0; i < 300; i++) rand_step("rand_b");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
